// File: rtl/fp_mul_sched_pkg.sv
// fp_mul_sched_pkg: shared widths and FSM state type for the FP multiply scheduler
package fp_mul_sched_pkg;
    localparam int FP_W = 32;
    localparam int CNT_W = 16;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_t;
endpackage

// File: rtl/fp_mul_sched_if.sv
// fp_mul_sched_if: requester-side and multiply-unit-side signals of the scheduler
interface fp_mul_sched_if #(parameter int NUM_REQ = 4);
    import fp_mul_sched_pkg::*;
    logic [NUM_REQ-1:0] req, gnt, rsp_valid;
    logic [NUM_REQ*FP_W-1:0] req_op1, req_op2;
    logic [FP_W-1:0] rsp_result, mul_op1, mul_op2, mul_result;
    logic rsp_ovf, rsp_err, mul_start, mul_done, mul_overflow, mul_busy;
    logic [CNT_W-1:0] ops_cnt;
    modport master (
        output req, req_op1, req_op2, mul_done, mul_result, mul_overflow, mul_busy,
        input gnt, rsp_valid, rsp_result, rsp_ovf, rsp_err, mul_start, mul_op1, mul_op2, ops_cnt
    );
    modport slave (
        input req, req_op1, req_op2, mul_done, mul_result, mul_overflow, mul_busy,
        output gnt, rsp_valid, rsp_result, rsp_ovf, rsp_err, mul_start, mul_op1, mul_op2, ops_cnt
    );
endinterface

// File: rtl/fp_mul_sched_rr_arbiter.sv
// rr_arbiter: combinational one-hot pick of the first request at or after ptr (circular)
module rr_arbiter #(parameter int N = 4) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    input  logic                 i_en,
    output logic [N-1:0]         o_gnt
);
    localparam int PW = $clog2(N);
    logic [PW-1:0] w_idx;
    always_comb begin
        o_gnt = '0;
        w_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = PW'((int'(i_ptr) + k) % N);
            if (i_en && i_req[w_idx]) o_gnt = N'(1) << w_idx;
        end
    end
endmodule

// File: rtl/fp_mul_sched.sv
// fp_mul_sched: round-robin scheduler sharing one FP multiplier; FP_MUL_SCHED_TIMEOUT_EN adds a WAIT watchdog
module fp_mul_sched
    import fp_mul_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input logic clk,
    input logic rst,
    fp_mul_sched_if.slave bus
);
    localparam int PW = $clog2(NUM_REQ);
    sched_state_t r_state, w_next;
    logic [PW-1:0] r_rr_ptr, r_owner, w_win;
    logic [NUM_REQ-1:0] w_gnt, r_gnt, r_rsp_valid;
    logic [FP_W-1:0] r_op1, r_op2, r_result;
    logic [CNT_W-1:0] r_cnt;
    logic r_mul_start, r_ovf, r_err, w_tmo, w_take, w_to_resp;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .i_req(bus.req),
        .i_ptr(r_rr_ptr),
        .i_en(r_state == IDLE && !bus.mul_busy),
        .o_gnt(w_gnt)
    );

    always_comb begin
        w_win = '0;
        for (int i = 0; i < NUM_REQ; i++) if (w_gnt[i]) w_win = PW'(i);
    end

    assign w_take = |w_gnt;
    assign w_to_resp = r_state == WAIT && (bus.mul_done || w_tmo);

`ifdef FP_MUL_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] r_wd;
    always_ff @(posedge clk) r_wd <= (rst || r_state != WAIT) ? '0 : r_wd + 1'b1;
    assign w_tmo = r_wd == WD_W'(TIMEOUT_CYC - 1);
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;

    always_comb begin
        w_next = (r_state == IDLE && w_take) ? ISSUE :
                 (r_state == ISSUE) ? WAIT :
                 w_to_resp ? RESP :
                 (r_state == RESP) ? IDLE : r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_owner <= '0;
            r_gnt <= '0;
            r_rsp_valid <= '0;
            r_op1 <= '0;
            r_op2 <= '0;
            r_result <= '0;
            r_mul_start <= 1'b0;
            r_ovf <= 1'b0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_gnt <= w_gnt;
            r_mul_start <= w_take;
            r_rsp_valid <= w_to_resp ? NUM_REQ'(1) << r_owner : '0;
            if (w_take) begin
                r_op1 <= bus.req_op1[{w_win, 5'd0} +: FP_W];
                r_op2 <= bus.req_op2[{w_win, 5'd0} +: FP_W];
                r_owner <= w_win;
                r_rr_ptr <= (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
            end
            // a watchdog abort reports a zero result with err set; done wins a same-cycle tie
            if (w_to_resp) begin
                r_result <= bus.mul_done ? bus.mul_result : '0;
                r_ovf <= bus.mul_done && bus.mul_overflow;
                r_err <= !bus.mul_done;
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.gnt = r_gnt;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_result = r_result;
    assign bus.rsp_ovf = r_ovf;
    assign bus.rsp_err = r_err;
    assign bus.mul_start = r_mul_start;
    assign bus.mul_op1 = r_op1;
    assign bus.mul_op2 = r_op2;
    assign bus.ops_cnt = r_cnt;
endmodule
